ssd_mux_driver: RTL and testbench



---
 rtl/ssd_pkg.sv | 82 ++++++++
 rtl/ssd_mux_driver_if.sv | 34 +++
 rtl/ssd_glyph_rom.sv | 47 ++++
 rtl/ssd_mux_driver.sv | 152 +++++++++++++++
 tb/tb_ssd_mux_driver.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - glyph codes, segment patterns and buffer entry type for the seven-segment driver
// Purpose : shared definitions for ssd_glyph_rom and ssd_mux_driver.
// Ports   : none (package).
package ssd_pkg;

    localparam int GLYPH_W = 5;

    typedef logic [GLYPH_W-1:0] glyph_t;

    // Active-low segment vector {g,f,e,d,c,b,a}; 0 = segment lit.
    typedef logic [6:0] seg_t;

    // One digit of a display message.
    typedef struct packed {
        glyph_t glyph;
        logic   dp;
        logic   blink;
    } digit_t;

    localparam glyph_t G_0     = 5'd0;
    localparam glyph_t G_1     = 5'd1;
    localparam glyph_t G_2     = 5'd2;
    localparam glyph_t G_3     = 5'd3;
    localparam glyph_t G_4     = 5'd4;
    localparam glyph_t G_5     = 5'd5;
    localparam glyph_t G_6     = 5'd6;
    localparam glyph_t G_7     = 5'd7;
    localparam glyph_t G_8     = 5'd8;
    localparam glyph_t G_9     = 5'd9;
    localparam glyph_t G_A     = 5'd10;
    localparam glyph_t G_B     = 5'd11;
    localparam glyph_t G_C     = 5'd12;
    localparam glyph_t G_D     = 5'd13;
    localparam glyph_t G_E     = 5'd14;
    localparam glyph_t G_F     = 5'd15;
    localparam glyph_t G_H     = 5'd16;
    localparam glyph_t G_L     = 5'd17;
    localparam glyph_t G_P     = 5'd18;
    localparam glyph_t G_R     = 5'd19;
    localparam glyph_t G_S     = 5'd20;
    localparam glyph_t G_T     = 5'd21;
    localparam glyph_t G_U     = 5'd22;
    localparam glyph_t G_Y     = 5'd23;
    localparam glyph_t G_DASH  = 5'd24;
    localparam glyph_t G_O     = 5'd25;
    localparam glyph_t G_N     = 5'd26;
    localparam glyph_t G_I     = 5'd27;
    localparam glyph_t G_BLANK = 5'd31;

    // Patterns are written as the lit-segment mask and inverted for the pins.
    localparam seg_t SEG_0     = ~7'h3F;
    localparam seg_t SEG_1     = ~7'h06;
    localparam seg_t SEG_2     = ~7'h5B;
    localparam seg_t SEG_3     = ~7'h4F;
    localparam seg_t SEG_4     = ~7'h66;
    localparam seg_t SEG_5     = ~7'h6D;
    localparam seg_t SEG_6     = ~7'h7D;
    localparam seg_t SEG_7     = ~7'h07;
    localparam seg_t SEG_8     = ~7'h7F;
    localparam seg_t SEG_9     = ~7'h6F;
    localparam seg_t SEG_A     = ~7'h77;
    localparam seg_t SEG_B     = ~7'h7C;
    localparam seg_t SEG_C     = ~7'h39;
    localparam seg_t SEG_D     = ~7'h5E;
    localparam seg_t SEG_E     = ~7'h79;
    localparam seg_t SEG_F     = ~7'h71;
    localparam seg_t SEG_H     = ~7'h76;
    localparam seg_t SEG_L     = ~7'h38;
    localparam seg_t SEG_P     = ~7'h73;
    localparam seg_t SEG_R     = ~7'h50;
    localparam seg_t SEG_S     = ~7'h6D;
    localparam seg_t SEG_T     = ~7'h78;
    localparam seg_t SEG_U     = ~7'h3E;
    localparam seg_t SEG_Y     = ~7'h6E;
    localparam seg_t SEG_DASH  = ~7'h40;
    localparam seg_t SEG_O     = ~7'h5C;
    localparam seg_t SEG_N     = ~7'h54;
    // Left-hand vertical bars so "I" is distinguishable from "1".
    localparam seg_t SEG_I     = ~7'h30;
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_mux_driver_if.sv
// rtl/ssd_mux_driver_if.sv - message load/ack bus between game control and the display driver
// Purpose : carries a full display message plus its load strobe and commit acknowledge.
// Ports   : msg_glyphs (5 bits per digit, digit 0 in [4:0]), msg_dp, msg_blink,
//           msg_load (1-cycle strobe), msg_ack (1-cycle commit pulse).
//           master = message producer, slave = ssd_mux_driver.
interface ssd_mux_driver_if
    import ssd_pkg::*;
#(
    parameter int N_DIGITS = 8
) ();

    logic [GLYPH_W*N_DIGITS-1:0] msg_glyphs;
    logic [N_DIGITS-1:0]         msg_dp;
    logic [N_DIGITS-1:0]         msg_blink;
    logic                        msg_load;
    logic                        msg_ack;

    modport master (
        output msg_glyphs,
        output msg_dp,
        output msg_blink,
        output msg_load,
        input  msg_ack
    );

    modport slave (
        input  msg_glyphs,
        input  msg_dp,
        input  msg_blink,
        input  msg_load,
        output msg_ack
    );

endinterface

// File: rtl/ssd_glyph_rom.sv
// rtl/ssd_glyph_rom.sv - combinational glyph code to active-low seven-segment decoder
// Purpose : maps a 5-bit glyph code to segments {g,f,e,d,c,b,a}; unknown codes are blank.
// Ports   : code (in, 5 bits), seg (out, 7 bits active-low).
module ssd_glyph_rom
    import ssd_pkg::*;
(
    input  glyph_t code,
    output seg_t   seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            G_0:     seg = SEG_0;
            G_1:     seg = SEG_1;
            G_2:     seg = SEG_2;
            G_3:     seg = SEG_3;
            G_4:     seg = SEG_4;
            G_5:     seg = SEG_5;
            G_6:     seg = SEG_6;
            G_7:     seg = SEG_7;
            G_8:     seg = SEG_8;
            G_9:     seg = SEG_9;
            G_A:     seg = SEG_A;
            G_B:     seg = SEG_B;
            G_C:     seg = SEG_C;
            G_D:     seg = SEG_D;
            G_E:     seg = SEG_E;
            G_F:     seg = SEG_F;
            G_H:     seg = SEG_H;
            G_L:     seg = SEG_L;
            G_P:     seg = SEG_P;
            G_R:     seg = SEG_R;
            G_S:     seg = SEG_S;
            G_T:     seg = SEG_T;
            G_U:     seg = SEG_U;
            G_Y:     seg = SEG_Y;
            G_DASH:  seg = SEG_DASH;
            G_O:     seg = SEG_O;
            G_N:     seg = SEG_N;
            G_I:     seg = SEG_I;
            G_BLANK: seg = SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// rtl/ssd_mux_driver.sv - time-multiplexed seven-segment driver with double-buffered messages
// Purpose : scans N_DIGITS digits, one per refresh tick, with ghost blanking after each
//           switch, per-digit blink and a shadow message committed only at frame end.
// Ports   : clk, rst_n (async active-low), enable (0 = all anodes off),
//           bus (slave: msg_glyphs/msg_dp/msg_blink/msg_load in, msg_ack out),
//           cathode (8, active-low {dp,g..a}), anode (N_DIGITS, active-low).
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 49999,
    parameter int BLINK_FRAMES = 64,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    ssd_mux_driver_if.slave     bus,
    output logic [7:0]          cathode,
    output logic [N_DIGITS-1:0] anode
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK_CYCLES);

    localparam digit_t DIGIT_BLANK = '{glyph: G_BLANK, dp: 1'b0, blink: 1'b0};

    logic [PRE_W-1:0] pre_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [BLK_W-1:0] blank_cnt;
    logic [FC_W-1:0]  frame_cnt;
    logic             blink_phase;
    logic             pending;
    logic             ack_q;

    digit_t active [N_DIGITS];
    digit_t shadow [N_DIGITS];
    digit_t msg_digits [N_DIGITS];

    logic   tick;
    logic   frame_end;
    digit_t cur_digit;
    seg_t   cur_seg;
    logic [7:0]          cathode_d;
    logic [N_DIGITS-1:0] anode_d;

    assign tick      = (pre_cnt == PRE_MAX);
    assign frame_end = tick && (digit_idx == IDX_LAST);

    // Refresh timebase: prescaler, digit scan index and post-switch blanking window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_idx <= '0;
            blank_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
                blank_cnt <= BLK_INIT;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BLK_W'(1);
            end
        end
    end

    // Blink phase flips once every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            msg_digits[i] = '{glyph: bus.msg_glyphs[i*GLYPH_W +: GLYPH_W],
                              dp:    bus.msg_dp[i],
                              blink: bus.msg_blink[i]};
        end
    end

    // Commit reads the shadow before this cycle's load overwrites it, so a load
    // landing on a committing frame end stays pending for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                active[i] <= DIGIT_BLANK;
                shadow[i] <= DIGIT_BLANK;
            end
            pending <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= frame_end && pending;
            if (frame_end && pending) begin
                active <= shadow;
            end
            if (bus.msg_load) begin
                shadow  <= msg_digits;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.msg_ack = ack_q;

    assign cur_digit = active[digit_idx];

    ssd_glyph_rom u_rom (
        .code (cur_digit.glyph),
        .seg  (cur_seg)
    );

    always_comb begin
        anode_d   = '1;
        cathode_d = 8'hFF;
        if (enable && (blank_cnt == '0)) begin
            anode_d = ~(N_DIGITS'(1) << digit_idx);
            // Blinked-off digits keep their anode so the scan duty is unchanged.
            if (!(cur_digit.blink && blink_phase)) begin
                cathode_d = {~cur_digit.dp, cur_seg};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode   <= '1;
            cathode <= 8'hFF;
        end else begin
            anode   <= anode_d;
            cathode <= cathode_d;
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// tb/tb_ssd_mux_driver.sv - self-checking bench for ssd_mux_driver against a cycle-indexed reference model
module tb_ssd_mux_driver;

    localparam int N  = 4;
    localparam int D  = 3;
    localparam int BF = 2;
    localparam int BC = 1;
    localparam int P  = D + 1;
    localparam int FR = N * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] cathode;
    logic [N-1:0] anode;

    ssd_mux_driver_if #(.N_DIGITS(N)) bus ();

    ssd_mux_driver #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (D),
        .BLINK_FRAMES (BF),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .bus     (bus),
        .cathode (cathode),
        .anode   (anode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;

    // Reference model: k = clock edges since reset release; timing derived from k arithmetically.
    int k;
    int a_glyph [N];
    int a_dp    [N];
    int a_blink [N];
    int s_glyph [N];
    int s_dp    [N];
    int s_blink [N];
    bit pend;
    int fc;
    bit phase;

    function automatic logic [6:0] lit(input int code);
        case (code)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
           12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  15: return 7'h71;
           16: return 7'h76;  17: return 7'h38;  18: return 7'h73;  19: return 7'h50;
           20: return 7'h6D;  21: return 7'h78;  22: return 7'h3E;  23: return 7'h6E;
           24: return 7'h40;  25: return 7'h5C;  26: return 7'h54;  27: return 7'h30;
           default: return 7'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        pend = 1'b0;
        fc = 0;
        phase = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_glyph[i] = 31; a_dp[i] = 0; a_blink[i] = 0;
            s_glyph[i] = 31; s_dp[i] = 0; s_blink[i] = 0;
        end
    endtask

    task automatic step();
        logic [N-1:0] ea;
        logic [7:0]   ec;
        logic         eack;
        int idx;
        bit tick, fend, blanked;
        tick    = (k % P) == D;
        idx     = (k / P) % N;
        fend    = tick && (idx == N - 1);
        blanked = (k >= P) && ((k % P) < BC);
        ea = '1;
        ec = 8'hFF;
        if (enable && !blanked) begin
            ea = ~(4'b0001 << idx);
            if (!(a_blink[idx] != 0 && phase))
                ec = {~a_dp[idx][0], ~lit(a_glyph[idx])};
        end
        eack = fend && pend;
        if (fend && pend) begin
            a_glyph = s_glyph; a_dp = s_dp; a_blink = s_blink;
            pend = 1'b0;
        end
        if (bus.msg_load) begin
            for (int i = 0; i < N; i++) begin
                s_glyph[i] = int'(bus.msg_glyphs[i*5 +: 5]);
                s_dp[i]    = int'(bus.msg_dp[i]);
                s_blink[i] = int'(bus.msg_blink[i]);
            end
            pend = 1'b1;
        end
        if (fend) begin
            if (fc == BF - 1) begin fc = 0; phase = !phase; end
            else fc++;
        end
        k++;
        @(posedge clk);
        #1;
        chk("anode", 32'(anode), 32'(ea));
        chk("cathode", 32'(cathode), 32'(ec));
        chk("msg_ack", 32'(bus.msg_ack), 32'(eack));
        if (bus.msg_ack) ack_count++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int m);
        for (int i = 0; i < FR && (k % FR) != m; i++) step();
    endtask

    task automatic load_msg(input int g0, input int g1, input int g2, input int g3,
                            input logic [N-1:0] dp, input logic [N-1:0] blink);
        bus.msg_glyphs = {5'(g3), 5'(g2), 5'(g1), 5'(g0)};
        bus.msg_dp     = dp;
        bus.msg_blink  = blink;
        bus.msg_load   = 1'b1;
        step();
        bus.msg_load   = 1'b0;
    endtask

    task automatic load_rand(input logic [N-1:0] blink);
        load_msg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), N'($urandom), blink);
    endtask

    task automatic do_reset(input int cycles);
        bus.msg_load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_cathode", 32'(cathode), 32'hFF);
        chk("rst_ack", 32'(bus.msg_ack), 32'h0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_anode", 32'(anode), 32'hF);
            chk("rst_hold_cathode", 32'(cathode), 32'hFF);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    int a0;

    initial begin
        bus.msg_glyphs = '0;
        bus.msg_dp     = '0;
        bus.msg_blink  = '0;
        bus.msg_load   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // 1: reset hold and blank scan
        do_reset(3);
        run(2 * FR);

        // 2: "P1 F" loaded mid-frame
        run_to(5);
        a0 = ack_count;
        load_msg(18, 1, 31, 15, 4'b0000, 4'b0000);
        run(FR + 4);
        chk("p1f_ack_count", 32'(ack_count - a0), 32'd1);
        run_to(2);
        chk("p1f_digit0_anode", 32'(anode), 32'hE);
        chk("p1f_digit0_cathode", 32'(cathode), 32'h8C);

        // 3: two loads in one frame, second wins
        run_to(1);
        a0 = ack_count;
        load_msg(16, 27, 21, 31, 4'b0000, 4'b0000);
        run(3);
        load_msg(20, 22, 26, 28, 4'b0010, 4'b0000);
        run_to(15);
        run(FR + 4);
        chk("two_loads_ack_count", 32'(ack_count - a0), 32'd1);
        run_to(2);
        chk("sunk_digit0_cathode", 32'(cathode), 32'h92);

        // 4: blink on digit 0 across several blink half-periods
        run_to(3);
        load_rand(4'b0001);
        run(6 * FR);

        // 6a: load coincident with a committing frame end, then display disabled
        run_to(3);
        a0 = ack_count;
        load_rand(4'b0000);
        run_to(15);
        load_rand(4'b0100);
        enable = 1'b0;
        run(3 * FR);
        chk("coincident_ack_count", 32'(ack_count - a0), 32'd2);
        chk("disabled_anode", 32'(anode), 32'hF);
        enable = 1'b1;
        run(FR);

        // random traffic: loads, enable toggles, blink masks
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) load_rand(N'($urandom));
            else step();
        end
        enable = 1'b1;
        run(2 * FR);

        // 6b: reset while a load is pending
        run_to(4);
        load_rand(4'b0000);
        run(3);
        a0 = ack_count;
        do_reset(2);
        run(3 * FR);
        chk("reset_pending_ack_count", 32'(ack_count - a0), 32'd0);
        run_to(2);
        chk("reset_blank_anode", 32'(anode), 32'hE);
        chk("reset_blank_cathode", 32'(cathode), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
